// File: rtl/iq_decimator.sv
`default_nettype none
// ============================================================================
// Module   : iq_decimator
// Purpose  : Boxcar-averaging I/Q decimator (D = 2^LOG2_DECIM) between the
//            sample FIFO and a push/stop downstream stage.
// Options  : DECIM_ROUND_EN - round half up before the shift (else truncate).
// Revision : 1.0 - initial release
// ============================================================================

package iq_decimator_pkg;
    typedef struct packed {
        logic signed [23:0] I;
        logic signed [23:0] Q;
    } Samp;
endpackage

module iq_decimator
    import iq_decimator_pkg::*;
#(
    parameter int LOG2_DECIM = 2
) (
    input  logic               Clk,
    input  logic               Reset,
    input  Samp                fifo_samp,
    input  logic               fifo_empty,
    output logic               fifo_PullOut,
    output logic signed [23:0] SampOutI,
    output logic signed [23:0] SampOutQ,
    output logic               PushOut,
    input  logic               StopOut
);
    localparam int c_DECIM = 1 << LOG2_DECIM;
    localparam int c_CW    = (LOG2_DECIM == 0) ? 1 : LOG2_DECIM;
    localparam int c_AW    = 24 + LOG2_DECIM;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(c_DECIM - 1);
`ifdef DECIM_ROUND_EN
    localparam logic signed [c_AW-1:0] c_ROUND = c_AW'(c_DECIM >> 1);
`else
    localparam logic signed [c_AW-1:0] c_ROUND = '0;
`endif

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_OUT   = 1'b1
    } state_t;

    state_t                   r_state;
    state_t                   w_next_state;
    logic [c_CW-1:0]          r_count;
    logic signed [c_AW-1:0]   r_acc_i;
    logic signed [c_AW-1:0]   r_acc_q;
    logic signed [23:0]       r_samp_i;
    logic signed [23:0]       r_samp_q;
    logic                     w_pull;
    logic                     w_last;
    logic signed [c_AW-1:0]   w_in_i;
    logic signed [c_AW-1:0]   w_in_q;
    logic signed [c_AW-1:0]   w_sum_i;
    logic signed [c_AW-1:0]   w_sum_q;
    logic signed [23:0]       w_out_i;
    logic signed [23:0]       w_out_q;

    // The accumulator width already covers D full-scale samples plus the
    // rounding offset, so the shifted result always fits in 24 bits.
    assign w_in_i  = c_AW'($signed(fifo_samp.I));
    assign w_in_q  = c_AW'($signed(fifo_samp.Q));
    assign w_sum_i = r_acc_i + w_in_i;
    assign w_sum_q = r_acc_q + w_in_q;
    assign w_out_i = 24'((w_sum_i + c_ROUND) >>> LOG2_DECIM);
    assign w_out_q = 24'((w_sum_q + c_ROUND) >>> LOG2_DECIM);
    assign w_last  = (r_count == c_LAST);

    always_comb begin
        w_next_state = r_state;
        w_pull       = 1'b0;
        case (r_state)
            ST_ACCUM: begin
                w_pull = !fifo_empty && !Reset;
                if (w_pull && w_last) begin
                    w_next_state = ST_OUT;
                end
            end
            ST_OUT: begin
                if (!StopOut) begin
                    w_next_state = ST_ACCUM;
                end
            end
            default: w_next_state = ST_ACCUM;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state  <= ST_ACCUM;
            r_count  <= '0;
            r_acc_i  <= '0;
            r_acc_q  <= '0;
            r_samp_i <= '0;
            r_samp_q <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_pull) begin
                if (w_last) begin
                    r_samp_i <= w_out_i;
                    r_samp_q <= w_out_q;
                    r_acc_i  <= '0;
                    r_acc_q  <= '0;
                    r_count  <= '0;
                end else begin
                    r_acc_i  <= w_sum_i;
                    r_acc_q  <= w_sum_q;
                    r_count  <= r_count + c_CW'(1);
                end
            end
        end
    end

    assign fifo_PullOut = w_pull;
    assign PushOut      = (r_state == ST_OUT);
    assign SampOutI     = r_samp_i;
    assign SampOutQ     = r_samp_q;

endmodule
`default_nettype wire

// File: tb/tb_iq_decimator.sv
`default_nettype none
// ============================================================================
// Module   : tb_iq_decimator
// Purpose  : Directed self-checking bench for iq_decimator (LOG2_DECIM = 2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_iq_decimator;
    import iq_decimator_pkg::*;

    logic               Clk = 1'b0;
    logic               Reset;
    Samp                fifo_samp;
    logic               fifo_empty;
    logic               fifo_PullOut;
    logic signed [23:0] SampOutI;
    logic signed [23:0] SampOutQ;
    logic               PushOut;
    logic               StopOut;

    int total = 0;
    int bad = 0;
    int pulls = 0;
    int bad_pull = 0;
    bit last_pull;
    Samp q[$];
    logic signed [23:0] rx_i[$];
    logic signed [23:0] rx_q[$];

`ifdef DECIM_ROUND_EN
    localparam logic signed [23:0] c_RND_I = 24'sd1;
    localparam logic signed [23:0] c_RND_Q = 24'sd0;
    localparam logic signed [23:0] c_BP_Q  = -24'sd2;
`else
    localparam logic signed [23:0] c_RND_I = 24'sd0;
    localparam logic signed [23:0] c_RND_Q = -24'sd1;
    localparam logic signed [23:0] c_BP_Q  = -24'sd3;
`endif

    iq_decimator #(.LOG2_DECIM(2)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .fifo_samp    (fifo_samp),
        .fifo_empty   (fifo_empty),
        .fifo_PullOut (fifo_PullOut),
        .SampOutI     (SampOutI),
        .SampOutQ     (SampOutQ),
        .PushOut      (PushOut),
        .StopOut      (StopOut)
    );

    always #5 Clk = ~Clk;

    function automatic logic signed [23:0] avg4(input longint s);
        longint r;
        r = s;
`ifdef DECIM_ROUND_EN
        r = s + 2;
`endif
        return 24'(r >>> 2);
    endfunction

    task automatic push(input int i, input int qv);
        Samp s;
        s.I = 24'(i);
        s.Q = 24'(qv);
        q.push_back(s);
    endtask

    // One clock: drive FIFO head at the falling edge, observe just after,
    // then advance to the next falling edge.
    task automatic step(input bit gap);
        fifo_empty = gap || (q.size() == 0);
        fifo_samp  = (q.size() != 0) ? q[0] : '0;
        #1;
        last_pull = fifo_PullOut;
        if (fifo_PullOut && fifo_empty) bad_pull++;
        if (PushOut && !StopOut) begin
            rx_i.push_back(SampOutI);
            rx_q.push_back(SampOutQ);
        end
        if (fifo_PullOut && q.size() != 0) begin
            void'(q.pop_front());
            pulls++;
        end
        @(negedge Clk);
    endtask

    task automatic run_until_push(input int budget);
        for (int k = 0; k < budget && !PushOut; k++) step(1'b0);
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        StopOut = 1'b0;
        for (int k = 0; k < 4; k++) push(5, -5);
        for (int k = 0; k < 3; k++) begin
            step(1'b0);
            total++; if (last_pull !== 1'b0) begin bad++; $display("FAIL reset_pull got=%0b exp=0", last_pull); end
            total++; if (PushOut !== 1'b0) begin bad++; $display("FAIL reset_push got=%0b exp=0", PushOut); end
            total++; if ({SampOutI, SampOutQ} !== 48'd0) begin bad++; $display("FAIL reset_samp got=%h exp=0", {SampOutI, SampOutQ}); end
        end
        Reset = 1'b0;
        step(1'b0);
        total++; if (last_pull !== 1'b1) begin bad++; $display("FAIL reset_first_pull got=%0b exp=1", last_pull); end
        StopOut = 1'b1;
        run_until_push(6);
        total++; if (PushOut !== 1'b1 || SampOutI !== 24'sd5 || SampOutQ !== -24'sd5)
            begin bad++; $display("FAIL reset_group got=%0b/%0d/%0d exp=1/5/-5", PushOut, SampOutI, SampOutQ); end
        StopOut = 1'b0;
        step(1'b0);
    endtask

    task automatic test_average;
        pulls = 0;
        StopOut = 1'b1;
        push(4, -4); push(8, -8); push(12, -12); push(16, -16);
        for (int k = 0; k < 3; k++) step(1'b0);
        total++; if (PushOut !== 1'b0) begin bad++; $display("FAIL avg_early_push got=%0b exp=0", PushOut); end
        step(1'b0);
        total++; if (pulls !== 4) begin bad++; $display("FAIL avg_pulls got=%0d exp=4", pulls); end
        total++; if (PushOut !== 1'b1) begin bad++; $display("FAIL avg_push got=%0b exp=1", PushOut); end
        total++; if (SampOutI !== 24'sd10) begin bad++; $display("FAIL avg_i got=%0d exp=10", SampOutI); end
        total++; if (SampOutQ !== -24'sd10) begin bad++; $display("FAIL avg_q got=%0d exp=-10", SampOutQ); end
        StopOut = 1'b0;
        step(1'b0);
        total++; if (PushOut !== 1'b0) begin bad++; $display("FAIL avg_push_clear got=%0b exp=0", PushOut); end
    endtask

    task automatic test_rounding;
        StopOut = 1'b1;
        push(1, -1); push(0, 0); push(0, 0); push(1, -1);
        run_until_push(8);
        total++; if (PushOut !== 1'b1 || SampOutI !== c_RND_I)
            begin bad++; $display("FAIL round_i got=%0d exp=%0d", SampOutI, c_RND_I); end
        total++; if (SampOutQ !== c_RND_Q) begin bad++; $display("FAIL round_q got=%0d exp=%0d", SampOutQ, c_RND_Q); end
        StopOut = 1'b0;
        step(1'b0);
    endtask

    task automatic test_backpressure;
        int p0;
        StopOut = 1'b1;
        push(100, -1); push(200, -2); push(300, -3); push(400, -4);
        for (int k = 0; k < 4; k++) push(7, 0);
        for (int k = 0; k < 4; k++) step(1'b0);
        p0 = pulls;
        for (int k = 0; k < 5; k++) begin
            step(1'b0);
            total++; if (PushOut !== 1'b1 || SampOutI !== 24'sd250 || SampOutQ !== c_BP_Q)
                begin bad++; $display("FAIL bp_hold got=%0b/%0d/%0d exp=1/250/%0d", PushOut, SampOutI, SampOutQ, c_BP_Q); end
        end
        total++; if (pulls !== p0) begin bad++; $display("FAIL bp_no_pull got=%0d exp=%0d", pulls, p0); end
        rx_i.delete(); rx_q.delete();
        StopOut = 1'b0;
        step(1'b0);
        total++; if (rx_i.size() !== 1 || PushOut !== 1'b0)
            begin bad++; $display("FAIL bp_transfer got=%0d/%0b exp=1/0", rx_i.size(), PushOut); end
        step(1'b0);
        total++; if (last_pull !== 1'b1) begin bad++; $display("FAIL bp_next_pull got=%0b exp=1", last_pull); end
        StopOut = 1'b1;
        run_until_push(6);
        total++; if (PushOut !== 1'b1 || SampOutI !== 24'sd7 || SampOutQ !== 24'sd0)
            begin bad++; $display("FAIL bp_next_group got=%0b/%0d/%0d exp=1/7/0", PushOut, SampOutI, SampOutQ); end
        StopOut = 1'b0;
        step(1'b0);
    endtask

    task automatic test_gaps;
        longint si[3];
        longint sq[3];
        int vi, vq;
        rx_i.delete(); rx_q.delete();
        for (int g = 0; g < 3; g++) begin
            si[g] = 0; sq[g] = 0;
        end
        for (int k = 0; k < 12; k++) begin
            vi = k * 37 - 100;
            vq = 5 - k * k * 1000;
            push(vi, vq);
            si[k / 4] += vi;
            sq[k / 4] += vq;
        end
        for (int n = 0; n < 300 && rx_i.size() < 3; n++) begin
            StopOut = ($urandom_range(0, 3) == 0);
            step($urandom_range(0, 2) == 0);
        end
        StopOut = 1'b0;
        total++; if (rx_i.size() !== 3) begin bad++; $display("FAIL gaps_count got=%0d exp=3", rx_i.size()); end
        total++; if (bad_pull !== 0) begin bad++; $display("FAIL gaps_underflow got=%0d exp=0", bad_pull); end
        for (int g = 0; g < 3 && g < rx_i.size(); g++) begin
            total++; if (rx_i[g] !== avg4(si[g]) || rx_q[g] !== avg4(sq[g]))
                begin bad++; $display("FAIL gaps_val%0d got=%0d/%0d exp=%0d/%0d", g, rx_i[g], rx_q[g], avg4(si[g]), avg4(sq[g])); end
        end
    endtask

    task automatic test_full_scale;
        StopOut = 1'b1;
        for (int k = 0; k < 4; k++) push(32'h7FFFFF, 32'h800000);
        run_until_push(8);
        total++; if (PushOut !== 1'b1 || SampOutI !== 24'h7FFFFF)
            begin bad++; $display("FAIL full_pos got=%h exp=7fffff", SampOutI); end
        total++; if (SampOutQ !== 24'h800000) begin bad++; $display("FAIL full_neg got=%h exp=800000", SampOutQ); end
        StopOut = 1'b0;
        step(1'b0);
    endtask

    task automatic test_reset_midgroup;
        StopOut = 1'b1;
        push(1000, 1000); push(1000, 1000);
        step(1'b0); step(1'b0);
        Reset = 1'b1;
        step(1'b0);
        Reset = 1'b0;
        push(8, -8); push(8, -8); push(4, -4); push(4, -4);
        run_until_push(8);
        total++; if (PushOut !== 1'b1 || SampOutI !== 24'sd6 || SampOutQ !== -24'sd6)
            begin bad++; $display("FAIL midreset got=%0b/%0d/%0d exp=1/6/-6", PushOut, SampOutI, SampOutQ); end
        StopOut = 1'b0;
        step(1'b0);
    endtask

    initial begin
        Reset = 1'b1;
        StopOut = 1'b0;
        fifo_empty = 1'b1;
        fifo_samp = '0;
        @(negedge Clk);
        test_reset();
        test_average();
        test_rounding();
        test_backpressure();
        test_gaps();
        test_full_scale();
        test_reset_midgroup();
        total++; if (bad_pull !== 0) begin bad++; $display("FAIL underflow_total got=%0d exp=0", bad_pull); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
